// File: rtl/spi_eeprom_bank_if.sv
// Byte-wide memory bus between a CPU bank decoder and the SPI EEPROM bank.
// The initiator raises bus_enable and holds it until busy is seen low.
interface spi_eeprom_bank_if #(
    parameter int ADDR_WIDTH = 12
);
    logic [ADDR_WIDTH-1:0] address;
    logic [7:0]            data_in;
    logic [7:0]            data_out;
    logic                  bus_enable;
    logic                  write_enable;
    logic                  busy;

    modport master (
        output address, data_in, bus_enable, write_enable,
        input  data_out, busy
    );

    modport slave (
        input  address, data_in, bus_enable, write_enable,
        output data_out, busy
    );
endinterface

// File: rtl/spi_eeprom_bank.sv
// Serves one CPU memory bank from a 25LC-series SPI EEPROM (SPI mode 0).
// Reads are a single READ frame; writes issue WREN, WRITE and optionally
// poll RDSR until the EEPROM's internal write cycle completes.
module spi_eeprom_bank #(
    parameter int ADDR_WIDTH  = 12,
    parameter int HALF_PERIOD = 1,
    parameter int POLL_WRITE  = 1,
    parameter int POLL_MAX    = 255
) (
    input  logic                clk,
    input  logic                reset,
    spi_eeprom_bank_if.slave    bus,
    output logic                spi_cs,
    output logic                spi_clk,
    output logic                spi_do,
    input  logic                spi_di
);

    localparam int HW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int GW = $clog2(2 * HALF_PERIOD);
    localparam int PW = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;

    localparam logic [HW-1:0] H_LAST = HW'(HALF_PERIOD - 1);
    localparam logic [GW-1:0] G_LAST = GW'(2 * HALF_PERIOD - 1);
    localparam logic [PW-1:0] P_LAST = PW'(POLL_MAX - 1);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WREN     = 3'd1;
    localparam logic [2:0] ST_GAP      = 3'd2;
    localparam logic [2:0] ST_CMD_ADDR = 3'd3;
    localparam logic [2:0] ST_DATA     = 3'd4;
    localparam logic [2:0] ST_POLL     = 3'd5;
    localparam logic [2:0] ST_DONE     = 3'd6;

    localparam logic [31:0] WREN_WORD = {8'h06, 24'h000000};
    localparam logic [31:0] RDSR_WORD = {8'h05, 24'h000000};

    logic [2:0]            state;
    logic [2:0]            gap_next;
    logic                  is_write;
    logic [15:0]           addr_q;
    logic [7:0]            wdata_q;
    logic [30:0]           tx_rest;
    logic [7:0]            rx_shift;
    logic [5:0]            bits_left;
    logic [HW-1:0]         h_cnt;
    logic [GW-1:0]         gap_cnt;
    logic [PW-1:0]         poll_cnt;

    logic [ADDR_WIDTH-1:0] addr_in;
    logic [15:0]           addr16;
    logic [31:0]           read_word;
    logic [31:0]           write_word;

    assign addr_in    = bus.address;
    assign addr16     = 16'(addr_in);
    assign read_word  = {8'h03, addr16, 8'h00};
    assign write_word = {8'h02, addr_q, wdata_q};

    // Stall the initiator from the acceptance cycle until the transaction is done.
    assign bus.busy = !reset &&
                      (((state != ST_IDLE) && (state != ST_DONE)) ||
                       ((state == ST_IDLE) && bus.bus_enable));

    // Transaction sequencer and SPI frame engine: frames are MSB-first, MOSI
    // changes on the SCLK fall, MISO is shifted in on the SCLK rise.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            gap_next     <= ST_IDLE;
            is_write     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            tx_rest      <= '0;
            rx_shift     <= '0;
            bits_left    <= '0;
            h_cnt        <= '0;
            gap_cnt      <= '0;
            poll_cnt     <= '0;
            bus.data_out <= 8'h00;
            spi_cs       <= 1'b1;
            spi_clk      <= 1'b0;
            spi_do       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.bus_enable) begin
                        addr_q   <= addr16;
                        wdata_q  <= bus.data_in;
                        is_write <= bus.write_enable;
                        poll_cnt <= '0;
                        h_cnt    <= '0;
                        spi_clk  <= 1'b0;
                        spi_cs   <= 1'b0;
                        if (bus.write_enable) begin
                            tx_rest   <= WREN_WORD[30:0];
                            spi_do    <= WREN_WORD[31];
                            bits_left <= 6'd8;
                            state     <= ST_WREN;
                        end else begin
                            tx_rest   <= read_word[30:0];
                            spi_do    <= read_word[31];
                            bits_left <= 6'd32;
                            state     <= ST_CMD_ADDR;
                        end
                    end
                end

                ST_GAP: begin
                    if (gap_cnt == G_LAST) begin
                        gap_cnt <= '0;
                        h_cnt   <= '0;
                        spi_clk <= 1'b0;
                        spi_cs  <= 1'b0;
                        if (gap_next == ST_POLL) begin
                            tx_rest   <= RDSR_WORD[30:0];
                            spi_do    <= RDSR_WORD[31];
                            bits_left <= 6'd16;
                        end else begin
                            tx_rest   <= write_word[30:0];
                            spi_do    <= write_word[31];
                            bits_left <= 6'd32;
                        end
                        state <= gap_next;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                ST_WREN, ST_CMD_ADDR, ST_DATA, ST_POLL: begin
                    if (h_cnt != H_LAST) begin
                        h_cnt <= h_cnt + 1'b1;
                    end else begin
                        h_cnt <= '0;
                        if (!spi_clk) begin
                            spi_clk  <= 1'b1;
                            rx_shift <= {rx_shift[6:0], spi_di};
                        end else begin
                            spi_clk <= 1'b0;
                            if (bits_left != 6'd1) begin
                                bits_left <= bits_left - 6'd1;
                                spi_do    <= tx_rest[30];
                                tx_rest   <= {tx_rest[29:0], 1'b0};
                                if ((state == ST_CMD_ADDR) && (bits_left == 6'd9))
                                    state <= ST_DATA;
                            end else begin
                                spi_cs  <= 1'b1;
                                spi_do  <= 1'b0;
                                gap_cnt <= '0;
                                case (state)
                                    ST_WREN: begin
                                        gap_next <= ST_CMD_ADDR;
                                        state    <= ST_GAP;
                                    end
                                    ST_DATA: begin
                                        if (!is_write) begin
                                            bus.data_out <= rx_shift;
                                            state        <= ST_DONE;
                                        end else if (POLL_WRITE != 0) begin
                                            gap_next <= ST_POLL;
                                            state    <= ST_GAP;
                                        end else begin
                                            state <= ST_DONE;
                                        end
                                    end
                                    ST_POLL: begin
                                        if (rx_shift[0] && (poll_cnt != P_LAST)) begin
                                            poll_cnt <= poll_cnt + 1'b1;
                                            gap_next <= ST_POLL;
                                            state    <= ST_GAP;
                                        end else begin
                                            state <= ST_DONE;
                                        end
                                    end
                                    default: state <= ST_DONE;
                                endcase
                            end
                        end
                    end
                end

                ST_DONE: begin
                    if (!bus.bus_enable)
                        state <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_eeprom_bank.sv
// Self-checking bench for spi_eeprom_bank: a behavioural 25LC EEPROM model
// on a H=1 instance, plus a H=3 instance for SCLK/CS timing.
module tb_spi_eeprom_bank;

    localparam int TIMEOUT = 2000;

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [7:0]  wdata;
        int          wip;
        logic        stuck;
        logic [7:0]  exp_data;
        int          exp_lat;
        int          exp_frames;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic spi_cs, spi_clk, spi_do, spi_di;
    logic spi_cs3, spi_clk3, spi_do3;
    logic spi_di3 = 1'b1;

    int checks = 0;
    int errors = 0;

    spi_eeprom_bank_if #(.ADDR_WIDTH(12)) bus ();
    spi_eeprom_bank_if #(.ADDR_WIDTH(12)) bus3 ();

    spi_eeprom_bank #(.ADDR_WIDTH(12), .HALF_PERIOD(1), .POLL_WRITE(1), .POLL_MAX(4)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .spi_cs(spi_cs), .spi_clk(spi_clk), .spi_do(spi_do), .spi_di(spi_di)
    );

    spi_eeprom_bank #(.ADDR_WIDTH(12), .HALF_PERIOD(3), .POLL_WRITE(0), .POLL_MAX(255)) dut3 (
        .clk(clk), .reset(reset), .bus(bus3),
        .spi_cs(spi_cs3), .spi_clk(spi_clk3), .spi_do(spi_do3), .spi_di(spi_di3)
    );

    always #5 clk = ~clk;

    // EEPROM model state
    logic [7:0]  mem [0:4095];
    int          m_cnt = 0;
    logic [31:0] m_sh = '0;
    logic [7:0]  m_cmd = 8'h00;
    logic [7:0]  m_out = 8'h00;
    logic [7:0]  m_status;
    logic        m_wel = 1'b0;
    int          m_wip = 0;
    logic        m_miso = 1'b0;
    int          cs_falls = 0;
    logic [31:0] log_bits[$];
    int          log_len[$];
    int          wip_cfg = 0;
    logic        stuck = 1'b0;

    assign spi_di   = stuck ? 1'b1 : m_miso;
    assign m_status = {7'b0, (m_wip > 0)};

    // Start of a frame: clear the bit counter and the command.
    always @(negedge spi_cs) begin
        m_cnt = 0;
        m_sh  = '0;
        m_cmd = 8'h00;
        cs_falls++;
    end

    // Capture MOSI on the SCLK rise and decode command/address.
    always @(posedge spi_clk) begin
        if (!spi_cs) begin
            m_sh = {m_sh[30:0], spi_do};
            m_cnt++;
            if (m_cnt == 8)  m_cmd = m_sh[7:0];
            if (m_cnt == 24) m_out = mem[m_sh[11:0]];
        end
    end

    // Drive MISO on the SCLK fall for read data and status bits.
    always @(negedge spi_clk) begin
        if (!spi_cs) begin
            if (m_cmd == 8'h03 && m_cnt >= 24 && m_cnt < 32)
                m_miso = m_out[31 - m_cnt];
            else if (m_cmd == 8'h05 && m_cnt >= 8 && m_cnt < 16)
                m_miso = m_status[15 - m_cnt];
            else
                m_miso = 1'b0;
        end
    end

    // End of frame: log it and commit WREN/WRITE/RDSR side effects.
    always @(posedge spi_cs) begin
        if (m_cnt > 0) begin
            log_bits.push_back(m_sh);
            log_len.push_back(m_cnt);
        end
        if (m_cmd == 8'h06 && m_cnt == 8) m_wel = 1'b1;
        if (m_cmd == 8'h02 && m_cnt == 32 && m_wel) begin
            mem[m_sh[19:8]] = m_sh[7:0];
            m_wel = 1'b0;
            m_wip = wip_cfg;
        end
        if (m_cmd == 8'h05 && m_cnt == 16 && m_wip > 0) m_wip--;
        m_miso = 1'b0;
    end

    // H=3 instance timing monitor: SCLK phase lengths and CS gaps.
    logic mon3_en = 1'b0;
    logic mon3_prev = 1'b0;
    int hi_run, lo_run, cs_run, hi_min, hi_max, lo_min, lo_max;
    logic seen_frame;
    int gaps[$];
    always @(negedge clk) begin
        if (mon3_en && !mon3_prev) begin
            hi_run = 0; lo_run = 0; cs_run = 0; seen_frame = 1'b0;
            hi_min = 1000; hi_max = 0; lo_min = 1000; lo_max = 0;
            gaps.delete();
        end
        if (mon3_en) begin
            if (!spi_cs3 && spi_clk3) hi_run++;
            else if (hi_run != 0) begin
                if (hi_run < hi_min) hi_min = hi_run;
                if (hi_run > hi_max) hi_max = hi_run;
                hi_run = 0;
            end
            if (!spi_cs3 && !spi_clk3) lo_run++;
            else if (lo_run != 0) begin
                if (lo_run < lo_min) lo_min = lo_run;
                if (lo_run > lo_max) lo_max = lo_run;
                lo_run = 0;
            end
            if (spi_cs3) cs_run++;
            else begin
                if (cs_run != 0 && seen_frame) gaps.push_back(cs_run);
                cs_run = 0;
                seen_frame = 1'b1;
            end
        end
        mon3_prev = mon3_en;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic waitNotBusy(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (bus.busy !== 1'b0 && lat < TIMEOUT);
    endtask

    task automatic applyStimulus(input vec_t v, output int lat, output logic acc_busy);
        @(negedge clk);
        stuck   = v.stuck;
        wip_cfg = v.wip;
        bus.address      = v.addr;
        bus.data_in      = v.wdata;
        bus.write_enable = v.we;
        bus.bus_enable   = 1'b1;
        #1 acc_busy = bus.busy;
        waitNotBusy(lat);
    endtask

    task automatic runVector(input vec_t v, input string tag);
        int lat;
        int base;
        int n;
        logic acc_busy;
        logic [31:0] ew[$];
        int el[$];
        base = log_len.size();
        applyStimulus(v, lat, acc_busy);
        checkOutput($sformatf("%s/busy_accept", tag), 32'(acc_busy), 32'd1);
        checkOutput($sformatf("%s/latency", tag), lat, v.exp_lat);
        checkOutput($sformatf("%s/data_out", tag), 32'(bus.data_out), 32'(v.exp_data));
        if (v.we) begin
            ew.push_back(32'h0000_0006);             el.push_back(8);
            ew.push_back({8'h02, 4'h0, v.addr, v.wdata}); el.push_back(32);
            for (int k = 2; k < v.exp_frames; k++) begin
                ew.push_back(32'h0000_0500); el.push_back(16);
            end
        end else begin
            ew.push_back({8'h03, 4'h0, v.addr, 8'h00}); el.push_back(32);
        end
        n = log_len.size() - base;
        checkOutput($sformatf("%s/frame_count", tag), n, ew.size());
        for (int i = 0; i < ew.size() && i < n; i++) begin
            checkOutput($sformatf("%s/frame%0d_word", tag, i), log_bits[base + i], ew[i]);
            checkOutput($sformatf("%s/frame%0d_len", tag, i), log_len[base + i], el[i]);
        end
        @(negedge clk);
        bus.bus_enable = 1'b0;
        stuck = 1'b0;
        @(negedge clk);
    endtask

    task automatic run3(input logic we, input int exp_lat, input string tag);
        int lat;
        @(negedge clk);
        bus3.address      = 12'h456;
        bus3.data_in      = 8'h81;
        bus3.write_enable = we;
        bus3.bus_enable   = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (bus3.busy !== 1'b0 && lat < TIMEOUT);
        checkOutput($sformatf("%s/latency", tag), lat, exp_lat);
        @(negedge clk);
        bus3.bus_enable = 1'b0;
        @(negedge clk);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput($sformatf("%s/spi_cs", tag), 32'(spi_cs), 32'd1);
        checkOutput($sformatf("%s/spi_clk", tag), 32'(spi_clk), 32'd0);
        checkOutput($sformatf("%s/spi_do", tag), 32'(spi_do), 32'd0);
        checkOutput($sformatf("%s/busy", tag), 32'(bus.busy), 32'd0);
        checkOutput($sformatf("%s/data_out", tag), 32'(bus.data_out), 32'h00);
    endtask

    vec_t vecs[10];
    vec_t hv;
    int lat, bad, falls0;

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'hFF;
        mem[12'h123] = 8'h5A;

        //           we    addr     wdata  wip stuck exp   lat  frames
        vecs[0] = '{1'b0, 12'h123, 8'h00, 0, 1'b0, 8'h5A, 65,  1};
        vecs[1] = '{1'b1, 12'hFFF, 8'hC3, 3, 1'b0, 8'h5A, 219, 6};
        vecs[2] = '{1'b0, 12'hFFF, 8'h00, 0, 1'b0, 8'hC3, 65,  1};
        vecs[3] = '{1'b1, 12'h000, 8'h11, 0, 1'b0, 8'hC3, 117, 3};
        vecs[4] = '{1'b0, 12'h000, 8'h00, 0, 1'b0, 8'h11, 65,  1};
        vecs[5] = '{1'b0, 12'h800, 8'h00, 0, 1'b0, 8'hFF, 65,  1};
        vecs[6] = '{1'b1, 12'h010, 8'h77, 0, 1'b1, 8'hFF, 219, 6};
        vecs[7] = '{1'b0, 12'h010, 8'h00, 0, 1'b0, 8'h77, 65,  1};
        vecs[8] = '{1'b1, 12'h123, 8'h00, 1, 1'b0, 8'h77, 151, 4};
        vecs[9] = '{1'b0, 12'h123, 8'h00, 0, 1'b0, 8'h00, 65,  1};

        bus.address = '0; bus.data_in = '0; bus.write_enable = 1'b0; bus.bus_enable = 1'b0;
        bus3.address = '0; bus3.data_in = '0; bus3.write_enable = 1'b0; bus3.bus_enable = 1'b0;

        repeat (3) @(negedge clk);
        checkResetState("reset");
        checkOutput("reset/dut3_data_out", 32'(bus3.data_out), 32'h00);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) runVector(vecs[i], $sformatf("vec%0d", i));

        // handshake: held request, address change mid-transfer, re-accept
        @(negedge clk);
        bus.address = 12'h000; bus.write_enable = 1'b0; bus.data_in = 8'h00; bus.bus_enable = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 10) begin
                bus.address = 12'hFFF; bus.write_enable = 1'b1; bus.data_in = 8'hEE;
            end
        end while (bus.busy !== 1'b0 && lat < TIMEOUT);
        checkOutput("hs/latency", lat, 65);
        checkOutput("hs/data_out", 32'(bus.data_out), 32'h11);
        falls0 = cs_falls;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.busy !== 1'b0) bad++;
        end
        checkOutput("hs/hold_busy", bad, 0);
        checkOutput("hs/hold_cs_falls", cs_falls - falls0, 0);
        bus.bus_enable = 1'b0; bus.write_enable = 1'b0;
        @(negedge clk);
        bus.bus_enable = 1'b1;
        #1 checkOutput("hs/reaccept_busy", 32'(bus.busy), 32'd1);
        waitNotBusy(lat);
        checkOutput("hs/reaccept_latency", lat, 65);
        checkOutput("hs/reaccept_data", 32'(bus.data_out), 32'hC3);
        checkOutput("hs/reaccept_cs_falls", cs_falls - falls0, 1);
        @(negedge clk);
        bus.bus_enable = 1'b0;
        @(negedge clk);

        // reset while address bits are being shifted out
        bus.address = 12'hFFF; bus.write_enable = 1'b0; bus.bus_enable = 1'b1;
        repeat (30) @(negedge clk);
        reset = 1'b1; bus.bus_enable = 1'b0;
        #1 checkOutput("rst_addr/busy_in_reset", 32'(bus.busy), 32'd0);
        @(negedge clk);
        checkResetState("rst_addr");
        reset = 1'b0;
        @(negedge clk);
        hv = '{1'b0, 12'h000, 8'h00, 0, 1'b0, 8'h11, 65, 1};
        runVector(hv, "rst_addr_after");

        // reset while polling the status register
        @(negedge clk);
        wip_cfg = 50;
        bus.address = 12'h020; bus.data_in = 8'h3C; bus.write_enable = 1'b1; bus.bus_enable = 1'b1;
        repeat (100) @(negedge clk);
        reset = 1'b1; bus.bus_enable = 1'b0;
        #1 checkOutput("rst_poll/busy_in_reset", 32'(bus.busy), 32'd0);
        @(negedge clk);
        checkResetState("rst_poll");
        reset = 1'b0;
        @(negedge clk);
        hv = '{1'b0, 12'h020, 8'h00, 0, 1'b0, 8'h3C, 65, 1};
        runVector(hv, "rst_poll_after");

        // H=3 instance: latencies, SCLK phases and CS gap
        mon3_en = 1'b1;
        run3(1'b0, 193, "h3_read");
        mon3_en = 1'b0;
        checkOutput("h3_read/data_out", 32'(bus3.data_out), 32'hFF);
        checkOutput("h3_read/sclk_high", {hi_min[15:0], hi_max[15:0]}, {16'd3, 16'd3});
        checkOutput("h3_read/sclk_low", {lo_min[15:0], lo_max[15:0]}, {16'd3, 16'd3});
        @(negedge clk);
        mon3_en = 1'b1;
        run3(1'b1, 247, "h3_write");
        mon3_en = 1'b0;
        checkOutput("h3_write/data_out", 32'(bus3.data_out), 32'hFF);
        checkOutput("h3_write/gap_count", gaps.size(), 1);
        if (gaps.size() > 0) checkOutput("h3_write/gap_len", gaps[0], 6);
        checkOutput("h3_write/sclk_high", {hi_min[15:0], hi_max[15:0]}, {16'd3, 16'd3});
        checkOutput("h3_write/sclk_low", {lo_min[15:0], lo_max[15:0]}, {16'd3, 16'd3});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
